window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/window_3x3_gen_pkg.sv | 13 +
 rtl/window_3x3_gen_line_buffer.sv | 30 +++
 rtl/window_3x3_gen.sv | 106 ++++++++++
 tb/tb_window_3x3_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_gen_pkg.sv
// ------------------------------------------------------------
// window_3x3_gen_pkg : shared pixel width and default frame size
// Revision: 1.0
// ------------------------------------------------------------
`default_nettype none

package window_3x3_gen_pkg;
  localparam int PIX_W     = 8;
  localparam int DEF_IMG_W = 16;
  localparam int DEF_IMG_H = 16;
endpackage

`default_nettype wire

// File: rtl/window_3x3_gen_line_buffer.sv
// ------------------------------------------------------------
// line_buffer : indexed single-port delay line, read-before-write
// Revision: 1.0
// ------------------------------------------------------------
`default_nettype none

module line_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  // Storage is deliberately not reset; consumers gate on row position.
  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[idx];

  always_ff @(posedge clk) begin
    if (en) mem[idx] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/window_3x3_gen.sv
// ------------------------------------------------------------
// window_3x3_gen : raster-scan 3x3 neighbourhood window generator
// Revision: 1.0
// ------------------------------------------------------------
`default_nettype none

module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic [PIX_W-1:0] p9,
  output logic             win_valid,
  output logic             frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col, cur_col, nxt_col;
  logic [ROW_W-1:0] row, cur_row, nxt_row;
  logic [PIX_W-1:0] lb0_q, lb1_q;

  // sof forces the accepted pixel to (0,0) whatever the counters say.
  always_comb begin
    cur_col = sof ? '0 : col;
    cur_row = sof ? '0 : row;
    nxt_col = cur_col + COL_W'(1);
    nxt_row = cur_row;
    if (cur_col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
    end
  end

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .IDX_W(COL_W)) u_lb0 (
    .clk     (clk),
    .en      (pix_valid),
    .idx     (cur_col),
    .wr_data (pix_in),
    .rd_data (lb0_q)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .IDX_W(COL_W)) u_lb1 (
    .clk     (clk),
    .en      (pix_valid),
    .idx     (cur_col),
    .wr_data (lb0_q),
    .rd_data (lb1_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      p1         <= '0;
      p2         <= '0;
      p3         <= '0;
      p4         <= '0;
      p5         <= '0;
      p6         <= '0;
      p7         <= '0;
      p8         <= '0;
      p9         <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= pix_valid && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      frame_done <= pix_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (pix_valid) begin
        col <= nxt_col;
        row <= nxt_row;
        p1  <= p2;
        p2  <= p3;
        p3  <= lb1_q;
        p4  <= p5;
        p5  <= p6;
        p6  <= lb0_q;
        p7  <= p8;
        p8  <= p9;
        p9  <= pix_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
// ------------------------------------------------------------
// tb_window_3x3_gen : directed self-checking bench for window_3x3_gen
// Revision: 1.0
// ------------------------------------------------------------
`default_nettype none

module tb_window_3x3_gen;
  localparam int W = 16;
  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = 8'h00;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       win_valid, frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  window_3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .p4         (p4),
    .p5         (p5),
    .p6         (p6),
    .p7         (p7),
    .p8         (p8),
    .p9         (p9),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  logic [71:0] win;
  assign win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

  function automatic logic [7:0] pv(input int r, input int c, input logic [7:0] key);
    return 8'(16 * r + c) ^ key;
  endfunction

  // Window centred on (r-1,c-1), p1 in the top byte.
  function automatic logic [71:0] exp_window(input int r, input int c, input logic [7:0] key);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = (w << 8) | 72'(pv(r - 2 + i, c - 2 + j, key));
    return w;
  endfunction

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    pix_valid = v;
    sof       = s;
    pix_in    = d;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (win !== 72'h0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: win=%h win_valid=%b frame_done=%b, required all zero",
               tag, win, win_valid, frame_done);
    end
  endtask

  task automatic run_frame(input logic [7:0] key, input bit sof_first, input bit gaps,
                           input int npix, input string tag);
    int          nwin;
    int          nfd;
    int          r;
    int          c;
    int          n;
    bit          exp_v;
    bit          exp_fd;
    bit          last_ok;
    logic [71:0] last_win;
    nwin = 0;
    nfd = 0;
    last_ok = 1'b0;
    last_win = '0;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / W;
      c = idx % W;
      if (gaps) begin
        n = int'($urandom_range(0, 2));
        for (int k = 0; k < n; k++) begin
          step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
          checks++;
          if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle(%0d,%0d): win_valid=%b frame_done=%b, required 0 0",
                     tag, r, c, win_valid, frame_done);
          end
          if (last_ok) begin
            checks++;
            if (win !== last_win) begin
              errors++;
              $display("FAIL %s hold(%0d,%0d): win=%h, required %h", tag, r, c, win, last_win);
            end
          end
        end
      end
      step(1'b1, sof_first && idx == 0, pv(r, c, key));
      exp_v  = (r >= 2) && (c >= 2);
      exp_fd = (r == H - 1) && (c == W - 1);
      checks++;
      if (win_valid !== exp_v) begin
        errors++;
        $display("FAIL %s win_valid(%0d,%0d): got %b, required %b", tag, r, c, win_valid, exp_v);
      end
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL %s frame_done(%0d,%0d): got %b, required %b", tag, r, c, frame_done, exp_fd);
      end
      if (win_valid === 1'b1) nwin++;
      if (frame_done === 1'b1) nfd++;
      if (exp_v) begin
        last_win = exp_window(r, c, key);
        checks++;
        if (win !== last_win) begin
          errors++;
          $display("FAIL %s window(%0d,%0d): got %h, required %h", tag, r, c, win, last_win);
        end
      end
      last_ok = exp_v;
    end
    if (npix == W * H) begin
      checks++;
      if (nwin != (W - 2) * (H - 2)) begin
        errors++;
        $display("FAIL %s window_count: got %0d, required %0d", tag, nwin, (W - 2) * (H - 2));
      end
      checks++;
      if (nfd != 1) begin
        errors++;
        $display("FAIL %s frame_done_count: got %0d, required 1", tag, nfd);
      end
    end
  endtask

  task automatic check_last_centre(input logic [7:0] required, input string tag);
    checks++;
    if (p5 !== required) begin
      errors++;
      $display("FAIL %s last_p5: got %h, required %h", tag, p5, required);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    run_frame(8'h00, 1'b1, 1'b0, W * H, "full");
    check_last_centre(8'hEE, "full");
  endtask

  task automatic test_gaps();
    run_frame(8'h00, 1'b1, 1'b1, W * H, "gaps");
    check_last_centre(8'hEE, "gaps");
  endtask

  task automatic test_back_to_back();
    run_frame(8'h00, 1'b1, 1'b0, W * H, "b2b_f1");
    run_frame(8'hA5, 1'b1, 1'b0, W * H, "b2b_f2");
    check_last_centre(8'hEE ^ 8'hA5, "b2b_f2");
  endtask

  task automatic test_reset_mid_frame();
    run_frame(8'h00, 1'b1, 1'b0, 7 * W + 5, "pre_rst");
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    step(1'b1, 1'b0, 8'h55);
    check_all_zero("rst_held1");
    step(1'b1, 1'b1, 8'h66);
    check_all_zero("rst_held2");
    rst = 1'b0;
    run_frame(8'h00, 1'b0, 1'b0, W * H, "post_rst");
    check_last_centre(8'hEE, "post_rst");
  endtask

  task automatic test_sof_resync();
    run_frame(8'h00, 1'b1, 1'b0, 9 * W + 3, "pre_sof");
    run_frame(8'h3C, 1'b1, 1'b0, W * H, "resync");
    check_last_centre(8'hEE ^ 8'h3C, "resync");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_sof_resync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
